// File: rtl/ife_pkg.sv
// Shared types for the Instruction Flow Expander.
// Dispatcher FSM states and core index width helper.
package ife_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    ISSUE
  } ife_disp_state_e;

  function automatic int IFE_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ife_rr_arbiter.sv
// Combinational round-robin pick: first request at or
// after rr_ptr, wrapping modulo NUM_CORES.
module ife_rr_arbiter
  import ife_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]            req,
  input  logic [IFE_IDX_W(NUM_CORES)-1:0] rr_ptr,
  output logic                            grant_valid,
  output logic [IFE_IDX_W(NUM_CORES)-1:0] grant_idx
);

  localparam int IDX_W = IFE_IDX_W(NUM_CORES);

  int              idx;
  logic [IDX_W-1:0] idx_w;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      idx_w = IDX_W'(idx);
      if (req[idx_w]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

endmodule

// File: rtl/ife_dispatcher.sv
// IFE dispatch stage: buffers one task, picks an eligible
// core round-robin and issues over a per-core handshake.
module ife_dispatcher
  import ife_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int TASK_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 task_valid,
  output logic                 task_ready,
  input  logic [TASK_W-1:0]    task_data,
  input  logic [NUM_CORES-1:0] core_idle_mask,
  output logic [NUM_CORES-1:0] disp_valid,
  output logic [TASK_W-1:0]    disp_data,
  input  logic [NUM_CORES-1:0] disp_ready,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [NUM_CORES-1:0] core_busy,
  output logic [CNT_W-1:0]     dispatch_count
);

  localparam int IDX_W = IFE_IDX_W(NUM_CORES);

  ife_disp_state_e state, state_n;

  logic [TASK_W-1:0]    buf_q;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W-1:0]     rr_ptr;
  logic                 rdy_q;
  logic [NUM_CORES-1:0] busy_q;
  logic [NUM_CORES-1:0] busy_n;
  logic [CNT_W-1:0]     cnt_q;
  logic                 gnt_v;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 accept;
  logic                 hs;

  ife_rr_arbiter #(
    .NUM_CORES(NUM_CORES)
  ) u_arb (
    .req        (core_idle_mask & ~busy_q),
    .rr_ptr     (rr_ptr),
    .grant_valid(gnt_v),
    .grant_idx  (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    hs      = 1'b0;
    unique case (state)
      IDLE: begin
        if (task_valid && rdy_q) begin
          accept  = 1'b1;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (gnt_v) state_n = ISSUE;
      end
      ISSUE: begin
        if (disp_ready[sel]) begin
          hs      = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A new reservation outranks a same-cycle completion.
    busy_n = busy_q & ~core_done;
    if (hs) busy_n[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q  <= 1'b0;
      buf_q  <= '0;
      sel    <= '0;
      rr_ptr <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      rdy_q  <= (state_n == IDLE);
      busy_q <= busy_n;
      if (accept) buf_q <= task_data;
      if (state == SELECT && gnt_v) sel <= gnt_idx;
      if (hs) begin
        rr_ptr <= (sel == IDX_W'(NUM_CORES - 1))
                  ? '0 : sel + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    disp_valid = '0;
    if (state == ISSUE) disp_valid[sel] = 1'b1;
  end

  assign task_ready     = rdy_q;
  assign disp_data      = buf_q;
  assign core_busy      = busy_q;
  assign dispatch_count = cnt_q;

endmodule

// File: tb/tb_ife_dispatcher.sv
// Scoreboard bench for ife_dispatcher: stimulus queues the
// expected core/payload, a negedge monitor checks handshakes.
module tb_ife_dispatcher;

  localparam int NC = 4;
  localparam int TW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          task_valid = 1'b0;
  logic          task_ready;
  logic [TW-1:0] task_data = '0;
  logic [NC-1:0] core_idle_mask;
  logic [NC-1:0] disp_valid;
  logic [TW-1:0] disp_data;
  logic [NC-1:0] disp_ready = '1;
  logic [NC-1:0] core_done = '0;
  logic [NC-1:0] core_busy;
  logic [CW-1:0] dispatch_count;
  logic [NC-1:0] idle_drop = '0;

  int total = 0;
  int bad   = 0;

  int            exp_core[$];
  logic [TW-1:0] exp_data[$];

  assign core_idle_mask = ~core_busy & ~idle_drop;

  ife_dispatcher #(
    .NUM_CORES(NC),
    .TASK_W   (TW),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .task_valid    (task_valid),
    .task_ready    (task_ready),
    .task_data     (task_data),
    .core_idle_mask(core_idle_mask),
    .disp_valid    (disp_valid),
    .disp_data     (disp_data),
    .disp_ready    (disp_ready),
    .core_done     (core_done),
    .core_busy     (core_busy),
    .dispatch_count(dispatch_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (disp_valid & disp_ready) != '0) begin
      int c;
      c = -1;
      for (int i = 0; i < NC; i++)
        if (disp_valid[i]) c = i;
      total++;
      if (exp_core.size() == 0) begin
        bad++;
        $display("FAIL unexpected_dispatch: got core %0d data %h, wanted none",
                 c, disp_data);
      end else begin
        int            ec;
        logic [TW-1:0] ed;
        ec = exp_core.pop_front();
        ed = exp_data.pop_front();
        if (c != ec || disp_data !== ed ||
            $countones(disp_valid) != 1) begin
          bad++;
          $display("FAIL dispatch: got core %0d data %h valid %b, wanted core %0d data %h",
                   c, disp_data, disp_valid, ec, ed);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!task_ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(task_ready), 32'd1);
  endtask

  task automatic send(input logic [TW-1:0] d,
                      input int core,
                      input bit push);
    wait_ready();
    if (push) begin
      exp_core.push_back(core);
      exp_data.push_back(d);
    end
    task_valid = 1'b1;
    task_data  = d;
    tick();
    task_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [NC-1:0] m);
    core_done = m;
    tick();
    core_done = '0;
  endtask

  initial begin
    // reset
    repeat (3) tick();
    chk("rst_ready", 32'(task_ready), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_data", disp_data, 32'd0);
    chk("rst_busy", 32'(core_busy), 32'd0);
    chk("rst_count", 32'(dispatch_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(task_ready), 32'd1);

    // basic rotation, with latency on the first task
    send(32'hA0, 0, 1);
    chk("lat_select_valid", 32'(disp_valid), 32'd0);
    chk("lat_select_ready", 32'(task_ready), 32'd0);
    tick();
    chk("lat_issue_valid", 32'(disp_valid), 32'b0001);
    chk("lat_issue_data", disp_data, 32'hA0);
    tick();
    chk("b2b_ready", 32'(task_ready), 32'd1);
    chk("busy_after_a0", 32'(core_busy), 32'b0001);
    send(32'hA1, 1, 1);
    send(32'hA2, 2, 1);
    send(32'hA3, 3, 1);
    wait_ready();
    chk("rot_busy", 32'(core_busy), 32'b1111);
    chk("rot_count", 32'(dispatch_count), 32'd4);

    // stall until core 2 frees up
    send(32'hA4, 2, 1);
    for (int i = 0; i < 6; i++) begin
      chk("stall_ready", 32'(task_ready), 32'd0);
      chk("stall_valid", 32'(disp_valid), 32'd0);
      tick();
    end
    pulse_done(4'b0100);
    chk("stall_busy_clr", 32'(core_busy), 32'b1011);
    chk("stall_sel_valid", 32'(disp_valid), 32'd0);
    tick();
    chk("stall_issue", 32'(disp_valid), 32'b0100);
    wait_ready();
    chk("stall_busy", 32'(core_busy), 32'b1111);
    chk("stall_count", 32'(dispatch_count), 32'd5);

    // held payload on core 1, idle drops, core 0 frees
    pulse_done(4'b0010);
    disp_ready = 4'b1101;
    send(32'hB1, 1, 1);
    tick();
    idle_drop = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(disp_valid), 32'b0010);
      chk("hold_data", disp_data, 32'hB1);
      core_done = (i == 1) ? 4'b0001 : 4'b0000;
      tick();
    end
    core_done  = '0;
    disp_ready = '1;
    wait_ready();
    idle_drop = '0;
    chk("hold_busy", 32'(core_busy), 32'b1110);
    chk("hold_count", 32'(dispatch_count), 32'd6);

    // done and set on the same core in the same cycle
    send(32'hC0, 0, 1);
    tick();
    chk("sim_issue", 32'(disp_valid), 32'b0001);
    pulse_done(4'b0001);
    chk("sim_busy", 32'(core_busy), 32'b1111);
    chk("sim_ready", 32'(task_ready), 32'd1);
    pulse_done(4'b1000);
    chk("done_clr3", 32'(core_busy), 32'b0111);
    pulse_done(4'b1000);
    chk("stray_done", 32'(core_busy), 32'b0111);
    pulse_done(4'b0011);
    chk("multi_done", 32'(core_busy), 32'b0100);
    chk("sim_count", 32'(dispatch_count), 32'd7);

    // reset while issuing
    disp_ready = '0;
    send(32'hD0, 1, 0);
    tick();
    chk("mid_issue", 32'(disp_valid), 32'b0010);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(disp_valid), 32'd0);
    chk("mid_rst_busy", 32'(core_busy), 32'd0);
    chk("mid_rst_ready", 32'(task_ready), 32'd0);
    chk("mid_rst_count", 32'(dispatch_count), 32'd0);
    rst        = 1'b0;
    disp_ready = '1;
    tick();
    chk("mid_rel_ready", 32'(task_ready), 32'd1);

    // counter wrap at 2^CNT_W
    for (int i = 0; i < 16; i++) begin
      send(32'hE0 + 32'(i), i % NC, 1);
      wait_ready();
      if (i == 14)
        chk("wrap_pre", 32'(dispatch_count), 32'd15);
      pulse_done('1);
    end
    chk("wrap_zero", 32'(dispatch_count), 32'd0);

    begin
      int n;
      n = 0;
      while (exp_core.size() != 0 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("queue_empty", 32'(exp_core.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ife_dispatcher.md
# ife_dispatcher

Dispatch stage of the Instruction Flow Expander. It accepts instruction-flow tasks from the front end through a valid/ready handshake and picks a target core round-robin. A core is eligible only if it reports idle on `core_idle_mask` and the dispatcher has no outstanding reservation on it. Each issued task is handed to that core over a per-core valid/ready handshake. The block drives `core_busy` from its own reservation register; the core monitor turns that back into `core_idle_mask`, and the core's completion pulse clears the reservation.

## Interface
Parameters:
- `NUM_CORES`, default 4: number of cores; must be ≥ 2.
- `TASK_W`, default 32: task payload width.
- `CNT_W`, default 16: width of the dispatch counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `task_valid`  in  1  front end offers a task.
- `task_ready`  out  1  dispatcher can accept a task.
- `task_data`  in  TASK_W  task payload.
- `core_idle_mask`  in  NUM_CORES  bit i = 1 means core i is idle, from the core monitor.
- `disp_valid`  out  NUM_CORES  one-hot; bit i offers `disp_data` to core i.
- `disp_data`  out  TASK_W  payload being issued, shared by all cores.
- `disp_ready`  in  NUM_CORES  bit i = 1 means core i accepts.
- `core_done`  in  NUM_CORES  single-cycle completion pulse from core i.
- `core_busy`  out  NUM_CORES  reservation register; bit i = 1 means core i owns a task.
- `dispatch_count`  out  CNT_W  number of completed dispatch handshakes; wraps.

## Operation
- State machine with states IDLE, SELECT, ISSUE.
- **IDLE**
  - `task_ready` = 1.
  - On `task_valid && task_ready`: latch `task_data` into the task buffer and go to SELECT.
- **SELECT**
  - `task_ready` = 0.
  - Eligible set is `core_idle_mask & ~core_busy`.
  - Pick the first eligible index at or after `rr_ptr`, wrapping modulo NUM_CORES.
  - If the eligible set is non-empty: register the index in `sel` and go to ISSUE.
  - Otherwise stay in SELECT and re-evaluate every cycle (stall).
- **ISSUE**
  - `disp_valid[sel]` = 1, all other bits 0.
  - `disp_data` = task buffer, held stable until the handshake.
  - On `disp_ready[sel]`:
    - set `core_busy[sel]`;
    - `rr_ptr` ← (`sel`+1) mod NUM_CORES;
    - `dispatch_count` += 1;
    - go to IDLE.
  - Once in ISSUE the selection is committed. Deassertion of `core_idle_mask[sel]` does not abort or reselect.
  - `disp_ready` bits other than `sel` are ignored.
- **Reservation clear**
  - `core_done[i]` clears `core_busy[i]` on the next edge.
  - `core_done` on a core whose busy bit is 0 has no effect.
  - If `core_done[sel]` and the dispatch handshake on `sel` occur in the same cycle, the set wins: the bit ends at 1.
  - Several `core_done` bits may pulse together; each clears independently.
- `dispatch_count` wraps from 2^CNT_W−1 to 0.
- `rr_ptr` is $clog2(NUM_CORES) bits wide. It wraps from NUM_CORES−1 to 0, so non-power-of-2 NUM_CORES is legal.

## Timing
- **Reset values** (while `rst` is high, and on the edge it is sampled):
  - state = IDLE;
  - `task_ready` = 0 while `rst` is high, 1 from the first cycle after reset;
  - `disp_valid` = 0, `disp_data` = 0, `core_busy` = 0, `rr_ptr` = 0, `sel` = 0, `dispatch_count` = 0.
- **Latency:**
  - task accepted at edge N;
  - SELECT during cycle N+1;
  - `disp_valid` asserted from cycle N+2 at the earliest.
- **Back-to-back:** after the handshake at edge M, `task_ready` = 1 in cycle M+1. Peak throughput is one task per 3 cycles.
- **Busy visibility:** a `core_busy` bit set at edge M is visible in cycle M+1, so a following SELECT never picks that core again.
- `rst` asserted mid-operation (SELECT or ISSUE) discards the buffered task, drops `disp_valid` the following cycle, and clears all reservations.
- All outputs are registered or decoded from state and registers only. There is no combinational path from any input to any output.

## Structure
- Shared package `ife_pkg` holds:
  - state enum `ife_disp_state_e` (IDLE, SELECT, ISSUE);
  - localparam index width function/constant `IFE_IDX_W(NUM_CORES)`.
- Sub-module `ife_rr_arbiter`: purely combinational. Inputs are the request vector and `rr_ptr`; outputs are `grant_valid` and `grant_idx`. It is parameterised by NUM_CORES and reusable by later IFE blocks.
- The top level holds the FSM, the task buffer, the `core_busy` register, `rr_ptr` and the counter.

## Test plan
- **Reset/idle:** hold `rst` 3 cycles, then release.
  - During reset: all outputs 0.
  - Cycle after release: `task_ready` = 1.
- **Basic rotation:** NUM_CORES=4, all idle, every `disp_ready` = 1, 4 tasks 0xA0–0xA3 → dispatched to cores 0, 1, 2, 3 in order. After that `core_busy` = 4'b1111 and `dispatch_count` = 4.
- **Stall:** all `core_busy` set, 5th task 0xA4 accepted, then `core_done[2]` pulses 6 cycles later. Required response:
  - `task_ready` = 0 during the wait;
  - no `disp_valid` until `core_busy[2]` clears;
  - 0xA4 issued to core 2.
- **Held payload:** `disp_ready[1]` = 0 for 5 cycles, and `core_idle_mask[1]` drops during the wait → `disp_valid[1]` and `disp_data` stay stable with no reselect; handshake completes when ready rises.
- **Simultaneous done/set:** `core_done[sel]` pulsed in the handshake cycle → `core_busy[sel]` = 1 afterwards. A stray `core_done` on a non-busy core leaves `core_busy` unchanged.
- **Mid-operation reset and wrap:** assert `rst` during ISSUE → `disp_valid` = 0 and `core_busy` = 0 next cycle. Separately, preload `dispatch_count` to 0xFFFF via 65535 dispatches (or a CNT_W=4 build at 15) → the next dispatch wraps the counter to 0.
